inert_cal_ctrl: RTL
===================

# inert_cal_ctrl

Calibration sequencer for the inertial integrator. It waits for the inertial interface to finish sensor init and then lets the sensor settle. It issues the single-cycle `strt_cal` pulse and supervises `cal_done` with a timeout and bounded retries. It publishes ready/fail status to the flight controller and accepts host re-calibration requests. It sits between `inert_intf` (`init_done`, `vld`) and `inertial_integrator` (`strt_cal`, `cal_done`).

## Interface
- `SETTLE_WIDTH`, default 16: settle period = 2^SETTLE_WIDTH clk cycles.
- `TMO_WIDTH`, default 20: calibration timeout = 2^TMO_WIDTH clk cycles.
- `MAX_RETRY`, default 3: timeouts tolerated before FAIL; range 0..3.
- `WDOG_WIDTH`, default 14: `vld` watchdog span = 2^WDOG_WIDTH cycles.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `init_done` input 1: level; sensor init complete.
- `recal_req` input 1: host re-calibration request, sampled each cycle.
- `cal_done` input 1: one-cycle pulse from the integrator.
- `vld` input 1: new-sample pulse from `inert_intf`.
- `strt_cal` output 1: one-cycle calibration start pulse.
- `cal_busy` output 1: high in SETTLE, START and WAIT_CAL.
- `ready` output 1: high only in READY.
- `cal_fail` output 1: high only in FAIL.
- `retry_cnt` output 2: timeouts taken in the current calibration attempt.
- `vld_lost` output 1: sticky flag meaning no `vld` seen for a full watchdog span.

## Operation
- States: IDLE, SETTLE, START, WAIT_CAL, READY, FAIL.
- Reset (`rst_n` low at an edge) forces IDLE and clears all counters and `retry_cnt`. It also clears `vld_lost`. Every output is 0 after reset.
- IDLE: `init_done` high → SETTLE; the settle counter is cleared.
- SETTLE: the settle counter increments every cycle. When the counter is all ones → START. `recal_req` is ignored.
- START: `strt_cal`=1 for exactly this cycle → WAIT_CAL. The timeout counter and the watchdog are cleared, and `vld_lost` is cleared.
- WAIT_CAL: the timeout counter increments every cycle.
  - `cal_done` → READY; `retry_cnt` is held for visibility.
  - Timeout counter all ones and no `cal_done`, with `retry_cnt`==MAX_RETRY → FAIL.
  - Same timeout condition otherwise: `retry_cnt`+1 and → SETTLE with the settle counter cleared.
  - If `cal_done` and the timeout condition occur in the same cycle, `cal_done` wins.
  - `recal_req` is ignored.
- READY: `recal_req` → START directly, with no settle. `retry_cnt` clears on that transition.
- FAIL: `recal_req` → SETTLE; `retry_cnt` clears and the settle counter clears.
- `cal_done` arriving outside WAIT_CAL is ignored and causes no state change.
- `init_done` is looked at only in IDLE. It falling later has no effect.
- Outputs are a decode of the registered state plus registered flags, so no input-to-output combinational path exists.

## Timing
- `init_done` sampled high at edge k: SETTLE from k+1, START at k+1+2^SETTLE_WIDTH, and `strt_cal` high during that cycle only.
- `cal_done` sampled at edge m in WAIT_CAL: `ready`=1 from m+1.
- The timeout fires at the edge ending the 2^TMO_WIDTH-th WAIT_CAL cycle.
- `recal_req` in READY at edge r: `strt_cal` during the cycle after r; `ready` drops at r+1.
- Counters never wrap in use, because each is cleared on state entry.
- Reset mid-calibration aborts immediately. No `strt_cal` pulse is emitted in the cycle following reset.

## Configuration
- `INERT_CAL_VLD_WDOG_EN` defined:
  - A WDOG_WIDTH-bit counter runs in WAIT_CAL and READY. It clears on `vld` and saturates at all ones.
  - Saturation sets sticky `vld_lost`, which clears only on entering START or on reset.
  - In WAIT_CAL, `vld_lost` rising is treated as a timeout the same cycle, following the same retry/FAIL rule.
- `INERT_CAL_VLD_WDOG_EN` undefined: no watchdog hardware, `vld_lost` tied 0, and `vld` unused.

## Test plan
Parameters for all scenarios: SETTLE_WIDTH=3, TMO_WIDTH=4, MAX_RETRY=2, WDOG_WIDTH=3.
- Nominal: reset, `init_done`=1 at edge 2 → `strt_cal` single pulse 9 cycles later. Then `cal_done` 5 cycles after that → `ready`=1 the next cycle, `retry_cnt`=0.
- Retry: withhold `cal_done` → after 16 WAIT_CAL cycles `retry_cnt`=1, 8 SETTLE cycles, a second `strt_cal`. Then `cal_done` → READY with `retry_cnt`=1.
- Fail: never assert `cal_done` → three `strt_cal` pulses, then `cal_fail`=1 with `retry_cnt`=2. `recal_req` → SETTLE, `retry_cnt`=0.
- Collision and re-calibration:
  - `cal_done` in the same cycle as timeout → READY, `retry_cnt` unchanged.
  - `recal_req` in READY → `strt_cal` next cycle, `ready`=0.
  - `recal_req` in SETTLE/WAIT_CAL → ignored.
- Reset mid-WAIT_CAL: `rst_n` low for one edge → IDLE, all outputs 0, no stray `strt_cal` pulse.
- With `INERT_CAL_VLD_WDOG_EN`: stop `vld` in READY for 8 cycles → `vld_lost`=1, held through `recal_req`, cleared in START. Without the macro, `vld_lost` stays 0 for the same stimulus.

Source files
------------

// File: rtl/inert_cal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inert_cal_ctrl
// Description : Calibration sequencer for the inertial integrator. Waits for
//               sensor init, lets the sensor settle, issues a one-cycle
//               strt_cal pulse and supervises cal_done with a timeout and
//               bounded retries. Publishes ready / fail status and accepts
//               host re-calibration requests.
//               Optional feature macro: INERT_CAL_VLD_WDOG_EN (vld watchdog).
// Revision    : 1.0 - initial release
// ============================================================================
module inert_cal_ctrl #(
    parameter int SETTLE_WIDTH = 16,
    parameter int TMO_WIDTH    = 20,
    parameter int MAX_RETRY    = 3,
    parameter int WDOG_WIDTH   = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_done,
    input  logic       recal_req,
    input  logic       cal_done,
    input  logic       vld,
    output logic       strt_cal,
    output logic       cal_busy,
    output logic       ready,
    output logic       cal_fail,
    output logic [1:0] retry_cnt,
    output logic       vld_lost
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETTLE   = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_WAIT_CAL = 3'd3;
    localparam logic [2:0] S_READY    = 3'd4;
    localparam logic [2:0] S_FAIL     = 3'd5;

    localparam logic [SETTLE_WIDTH-1:0] c_SETTLE_MAX = '1;
    localparam logic [TMO_WIDTH-1:0]    c_TMO_MAX    = '1;
    localparam logic [1:0]              c_MAX_RETRY  = 2'(MAX_RETRY);

    logic [2:0]              r_state,      w_state_nxt;
    logic [SETTLE_WIDTH-1:0] r_settle_cnt, w_settle_nxt;
    logic [TMO_WIDTH-1:0]    r_tmo_cnt,    w_tmo_nxt;
    logic [1:0]              r_retry_cnt,  w_retry_nxt;
    logic                    r_vld_lost,   w_vld_lost_nxt;
    logic                    r_strt_cal;
    logic                    r_cal_busy;
    logic                    r_ready;
    logic                    r_cal_fail;

    // Watchdog saturation this cycle (always 0 when the watchdog is absent)
    logic                    w_wdog_set;
    // Watchdog saturation seen for the first time while waiting on cal_done
    logic                    w_wdog_trip;

`ifdef INERT_CAL_VLD_WDOG_EN
    localparam logic [WDOG_WIDTH-1:0] c_WDOG_MAX = '1;
    logic [WDOG_WIDTH-1:0] r_wdog_cnt, w_wdog_nxt;

    assign w_wdog_set = ((r_state == S_WAIT_CAL) || (r_state == S_READY)) &&
                        (r_wdog_cnt == c_WDOG_MAX);

    // Watchdog: restarts on each vld, saturates, cleared when entering START
    always_comb begin
        w_wdog_nxt = r_wdog_cnt;
        if (w_state_nxt == S_START) begin
            w_wdog_nxt = '0;
        end else if ((r_state == S_WAIT_CAL) || (r_state == S_READY)) begin
            if (vld) begin
                w_wdog_nxt = '0;
            end else if (r_wdog_cnt != c_WDOG_MAX) begin
                w_wdog_nxt = r_wdog_cnt + WDOG_WIDTH'(1);
            end
        end
    end
`else
    // Without the watchdog vld has no consumer
    logic w_unused_vld;
    assign w_unused_vld = vld;
    assign w_wdog_set   = 1'b0;
`endif

    assign w_wdog_trip = (r_state == S_WAIT_CAL) && w_wdog_set && !r_vld_lost;

    // Next-state, counter and sticky-flag logic for the sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_settle_nxt   = r_settle_cnt;
        w_tmo_nxt      = r_tmo_cnt;
        w_retry_nxt    = r_retry_cnt;
        w_vld_lost_nxt = r_vld_lost | w_wdog_set;

        case (r_state)
            S_IDLE: begin
                if (init_done) begin
                    w_state_nxt  = S_SETTLE;
                    w_settle_nxt = '0;
                end
            end
            S_SETTLE: begin
                w_settle_nxt = r_settle_cnt + SETTLE_WIDTH'(1);
                if (r_settle_cnt == c_SETTLE_MAX) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT_CAL;
                w_tmo_nxt   = '0;
            end
            S_WAIT_CAL: begin
                w_tmo_nxt = r_tmo_cnt + TMO_WIDTH'(1);
                // cal_done has priority over a coincident timeout
                if (cal_done) begin
                    w_state_nxt = S_READY;
                end else if ((r_tmo_cnt == c_TMO_MAX) || w_wdog_trip) begin
                    if (r_retry_cnt == c_MAX_RETRY) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_retry_nxt  = r_retry_cnt + 2'd1;
                        w_state_nxt  = S_SETTLE;
                        w_settle_nxt = '0;
                    end
                end
            end
            S_READY: begin
                if (recal_req) begin
                    w_state_nxt = S_START;
                    w_retry_nxt = 2'd0;
                end
            end
            S_FAIL: begin
                if (recal_req) begin
                    w_state_nxt  = S_SETTLE;
                    w_retry_nxt  = 2'd0;
                    w_settle_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A fresh calibration start forgets any earlier loss of vld
        if (w_state_nxt == S_START) begin
            w_vld_lost_nxt = 1'b0;
        end
    end

    // State, counters and registered output decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_retry_cnt  <= 2'd0;
            r_vld_lost   <= 1'b0;
            r_strt_cal   <= 1'b0;
            r_cal_busy   <= 1'b0;
            r_ready      <= 1'b0;
            r_cal_fail   <= 1'b0;
`ifdef INERT_CAL_VLD_WDOG_EN
            r_wdog_cnt   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_tmo_cnt    <= w_tmo_nxt;
            r_retry_cnt  <= w_retry_nxt;
            r_vld_lost   <= w_vld_lost_nxt;
            r_strt_cal   <= (w_state_nxt == S_START);
            r_cal_busy   <= (w_state_nxt == S_SETTLE) ||
                            (w_state_nxt == S_START)  ||
                            (w_state_nxt == S_WAIT_CAL);
            r_ready      <= (w_state_nxt == S_READY);
            r_cal_fail   <= (w_state_nxt == S_FAIL);
`ifdef INERT_CAL_VLD_WDOG_EN
            r_wdog_cnt   <= w_wdog_nxt;
`endif
        end
    end

    assign strt_cal  = r_strt_cal;
    assign cal_busy  = r_cal_busy;
    assign ready     = r_ready;
    assign cal_fail  = r_cal_fail;
    assign retry_cnt = r_retry_cnt;
    assign vld_lost  = r_vld_lost;

endmodule
`default_nettype wire
